// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg
// Shared definitions for the core step controller: FSM state encoding
// (as seen on the debug overlay), default timing parameters for the
// 50 MHz board clock, and a counter-width helper.

package step_ctrl_pkg;

    // Encoding is visible on the VGA debug overlay, so values are pinned.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } step_state_t;

    // 10 ms of stability at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    // 2 Hz free-run advance at 50 MHz.
    localparam int DEF_RUN_DIV         = 25000000;
    localparam int DEF_PC_W            = 32;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/step_debounce.sv
// step_debounce
// Two-flop synchronizer followed by a stability counter. The output level
// only follows the synchronized input once it has disagreed with the
// current level for DEBOUNCE_CYCLES consecutive clocks, giving a total
// latency of DEBOUNCE_CYCLES+2 clocks from a clean input edge.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   din    in   raw asynchronous input
//   level  out  debounced stable level (0 after reset)

module step_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Any agreement with the current level restarts the stability window,
    // so only an unbroken run of the opposite value is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/core_step_ctrl.sv
// core_step_ctrl
// Execution controller for the single-cycle RISC-V core. Converts the
// step push-button and run switch into a one-cycle core advance strobe
// (cpu_en), supporting single-step, divided free-run and a PC breakpoint.
//
// Build option: define STEP_BREAKPOINT_EN to include the PC breakpoint.
// Without it, sw_bp_en/bp_addr/pc are ignored, BREAK is unreachable and
// bp_hit is tied low.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   btn_step     in   raw step push-button (async, active-high)
//   sw_run       in   raw run switch (async, 1 = free-run)
//   sw_bp_en     in   breakpoint enable
//   bp_addr      in   breakpoint PC (word aligned)
//   pc           in   current core PC
//   cpu_en       out  one-cycle core advance strobe
//   halted       out  1 when not free-running (IDLE or BREAK)
//   bp_hit       out  1 while in BREAK
//   cycle_count  out  number of cpu_en pulses since reset (wraps)
//   state        out  FSM state for the debug display

module core_step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV,
    parameter int PC_W            = DEF_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_step,
    input  logic            sw_run,
    input  logic            sw_bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            cpu_en,
    output logic            halted,
    output logic            bp_hit,
    output logic [31:0]     cycle_count,
    output logic [1:0]      state
);

    localparam int               DIV_W    = cnt_width(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    step_state_t      state_q;
    step_state_t      state_next;
    logic             step_lvl;
    logic             step_prev;
    logic             run_lvl;
    logic             step_evt;
    logic             tick;
    logic             bp_match;
    logic             pulse;
    logic [DIV_W-1:0] div_q;
    logic             halted_q;
    logic [31:0]      count_q;

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_step),
        .level (step_lvl)
    );

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_db (
        .clk   (clk),
        .rst   (rst),
        .din   (sw_run),
        .level (run_lvl)
    );

    // A held button gives one event: only the rising edge of the stable level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_prev <= 1'b0;
        end else begin
            step_prev <= step_lvl;
        end
    end

    assign step_evt = step_lvl & ~step_prev;
    assign tick     = (state_q == ST_RUN) && (div_q == DIV_LAST);

`ifdef STEP_BREAKPOINT_EN
    assign bp_match = sw_bp_en && (pc == bp_addr);
`else
    assign bp_match = 1'b0;

    logic unused_bp_inputs;
    assign unused_bp_inputs = ^{sw_bp_en, bp_addr, pc};
`endif

    // The advance strobe is decoded from registered state only, so an
    // asynchronous reset removes an in-flight pulse immediately.
    always_comb begin
        state_next = state_q;
        pulse      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (step_evt) begin
                    pulse = 1'b1;
                end
                if (run_lvl) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Dropping the run switch wins over a same-cycle tick.
                if (!run_lvl) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    if (bp_match) begin
                        state_next = ST_BREAK;
                    end else begin
                        pulse = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (step_evt) begin
                    pulse      = 1'b1;
                    state_next = run_lvl ? ST_RUN : ST_IDLE;
                end else if (!run_lvl) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The divider only advances while staying in RUN; every entry into RUN
    // restarts it from zero, so the first pulse comes RUN_DIV cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b1;
            div_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_next;
            halted_q <= (state_next != ST_RUN);
            if ((state_q == ST_RUN) && (state_next == ST_RUN) && !tick) begin
                div_q <= div_q + 1'b1;
            end else begin
                div_q <= '0;
            end
            count_q <= count_q + {31'd0, pulse};
        end
    end

`ifdef STEP_BREAKPOINT_EN
    logic bp_hit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= (state_next == ST_BREAK);
        end
    end

    assign bp_hit = bp_hit_q;
`else
    assign bp_hit = 1'b0;
`endif

    assign cpu_en      = pulse;
    assign halted      = halted_q;
    assign cycle_count = count_q;
    assign state       = state_q;

endmodule
